// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C blocks.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_MACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
    logic scl_p_q, sda_p_q;
    logic scl_rise_q, scl_fall_q, start_q, stop_q;
    logic scl_now, sda_now;

    assign scl_now = scl_sync_q[SyncStages-1];
    assign sda_now = sda_sync_q[SyncStages-1];

    // Sync chains reset to the idle-bus level so release never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl};
            sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_in};
            scl_p_q    <= scl_now;
            sda_p_q    <= sda_now;
            scl_rise_q <= scl_now & ~scl_p_q;
            scl_fall_q <= ~scl_now & scl_p_q;
            start_q    <= scl_now & scl_p_q & ~sda_now & sda_p_q;
            stop_q     <= scl_now & scl_p_q & sda_now & ~sda_p_q;
        end
    end

    assign scl_rise = scl_rise_q;
    assign scl_fall = scl_fall_q;
    assign start    = start_q;
    assign stop     = stop_q;
    assign sda_s    = sda_p_q;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target turning bus transactions into register read/write strobes.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2CAddress = 7'h7f,
    parameter int         SyncStages = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_sync #(.SyncStages(SyncStages)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    i2c_state_e state_q;
    logic [2:0] cnt_q;
    logic [6:0] shift_q;
    logic [7:0] tx_q, addr_q, wdata_q, byte_in;
    logic       rw_q, wr_q, rd_q, oe_q, busy_q;

    assign byte_in = {shift_q, sda_s};

    // ACK states use cnt_q as a phase: 0 = waiting to drive ACK, 1/2 = ACK bit in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= I2C_WRITE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            if (wr_q) addr_q <= addr_q + 8'd1;
            if (rd_q) tx_q <= reg_rdata;
            if (stop) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (start) begin
                state_q <= ADDR;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        shift_q <= byte_in[6:0];
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            cnt_q   <= '0;
                            state_q <= (byte_in[7:1] == I2CAddress) ? ADDR_ACK : IGNORE;
                            if (byte_in[7:1] == I2CAddress) begin
                                rw_q   <= byte_in[0];
                                busy_q <= 1'b1;
                            end
                        end
                    end
                    REG, WDATA: if (scl_rise) begin
                        shift_q <= byte_in[6:0];
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            cnt_q   <= '0;
                            state_q <= (state_q == REG) ? REG_ACK : WDATA_ACK;
                            if (state_q == REG) addr_q <= byte_in;
                            else wdata_q <= byte_in;
                        end
                    end
                    ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            oe_q  <= 1'b1;
                            cnt_q <= 3'd1;
                            rd_q  <= (state_q == ADDR_ACK) && (rw_q == I2C_READ);
                            wr_q  <= (state_q == WDATA_ACK);
                        end else begin
                            cnt_q   <= '0;
                            oe_q    <= 1'b0;
                            state_q <= (state_q != ADDR_ACK) ? WDATA :
                                       (rw_q == I2C_READ) ? RDATA : REG;
                            if (state_q == ADDR_ACK && rw_q == I2C_READ) begin
                                oe_q <= ~tx_q[7];
                                tx_q <= {tx_q[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            oe_q <= ~tx_q[7];
                            tx_q <= {tx_q[6:0], 1'b0};
                        end
                        if (scl_rise) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                cnt_q   <= '0;
                                state_q <= RDATA_MACK;
                            end
                        end
                    end
                    RDATA_MACK: begin
                        if (scl_fall && cnt_q == 3'd0) begin
                            oe_q  <= 1'b0;
                            cnt_q <= 3'd1;
                        end
                        if (scl_rise && cnt_q == 3'd1) begin
                            cnt_q   <= sda_s ? 3'd0 : 3'd2;
                            state_q <= sda_s ? IGNORE : RDATA_MACK;
                            if (!sda_s) begin
                                addr_q <= addr_q + 8'd1;
                                rd_q   <= 1'b1;
                            end
                        end
                        if (scl_fall && cnt_q == 3'd2) begin
                            cnt_q   <= '0;
                            state_q <= RDATA;
                            oe_q    <= ~tx_q[7];
                            tx_q    <= {tx_q[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = wdata_q;
    assign reg_rd    = rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bus-level scenarios against i2c_target_regs with a register-file model.
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       reset, scl, sda_m, sda_in;
    logic       sda_oe, reg_wr, reg_rd, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic [7:0] regs [256];

    int tests = 0, fails = 0;
    logic [7:0] wr_a[$], wr_d[$];
    int rd_n = 0, both_n = 0, hi_chg = 0, oe_n = 0, busy_n = 0;
    logic oe_prev = 1'b0;

    i2c_target_regs #(.I2CAddress(7'h7f), .SyncStages(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign sda_in    = sda_m & ~sda_oe;
    assign reg_rdata = regs[reg_addr];

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wdata);
        end
        if (reg_rd) rd_n++;
        if (reg_wr && reg_rd) both_n++;
        if (sda_oe) oe_n++;
        if (busy) busy_n++;
        if (scl && sda_oe !== oe_prev) hi_chg++;
        oe_prev = sda_oe;
    end

    task automatic quarter();
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;
        quarter();
        scl = 1'b1;
        quarter();
        r = sda_in;
        quarter();
        scl = 1'b0;
        quarter();
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        quarter();
        scl = 1'b1;
        quarter();
        sda_m = 1'b0;
        quarter();
        scl = 1'b0;
        quarter();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        quarter();
        scl = 1'b1;
        quarter();
        sda_m = 1'b1;
        quarter();
        quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
        bus_bit(mack, r);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        tests++; if (reg_addr !== 8'h00) begin fails++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
        tests++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin fails++; $display("FAIL reset_strobes got wr=%b rd=%b want 0 0", reg_wr, reg_rd); end
        tests++; if (reg_wdata !== 8'h00) begin fails++; $display("FAIL reset_reg_wdata got %h want 00", reg_wdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        quarter();
    endtask

    task automatic run_single(input string tag);
        logic ack;
        int   w0;
        w0 = wr_a.size();
        bus_start();
        write_byte(8'hFE, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL %s_addr_ack got %b want 0", tag, ack); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_mid got %b want 1", tag, busy); end
        write_byte(8'h87, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL %s_reg_ack got %b want 0", tag, ack); end
        write_byte(8'h40, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL %s_data_ack got %b want 0", tag, ack); end
        bus_stop();
        quarter();
        tests++; if (wr_a.size() - w0 != 1) begin fails++; $display("FAIL %s_wr_count got %0d want 1", tag, wr_a.size() - w0); end
        tests++; if (wr_a[w0] !== 8'h87 || wr_d[w0] !== 8'h40) begin fails++; $display("FAIL %s_wr_value got %h/%h want 87/40", tag, wr_a[w0], wr_d[w0]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after_stop got %b want 0", tag, busy); end
        tests++; if (reg_addr !== 8'h88) begin fails++; $display("FAIL %s_addr_incr got %h want 88", tag, reg_addr); end
    endtask

    task automatic test_single_write();
        run_single("single");
    endtask

    task automatic test_burst_write();
        logic [7:0] data [6] = '{8'h01, 8'hc2, 8'hd1, 8'he1, 8'h27, 8'h88};
        logic ack;
        int   w0;
        w0 = wr_a.size();
        bus_start();
        write_byte(8'hFE, ack);
        write_byte(8'h07, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL burst_reg_ack got %b want 0", ack); end
        for (int i = 0; i < 6; i++) begin
            write_byte(data[i], ack);
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL burst_ack%0d got %b want 0", i, ack); end
        end
        bus_stop();
        quarter();
        tests++; if (wr_a.size() - w0 != 6) begin fails++; $display("FAIL burst_count got %0d want 6", wr_a.size() - w0); end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (wr_a[w0+i] !== 8'h07 + 8'(i) || wr_d[w0+i] !== data[i]) begin
                fails++;
                $display("FAIL burst_wr%0d got %h/%h want %h/%h", i, wr_a[w0+i], wr_d[w0+i], 8'h07 + 8'(i), data[i]);
            end
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         w0, r0;
        regs[7] = 8'h01;
        regs[8] = 8'hc2;
        w0 = wr_a.size();
        r0 = rd_n;
        bus_start();
        write_byte(8'hFE, ack);
        write_byte(8'h07, ack);
        bus_start();
        write_byte(8'hFF, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL read_addr_ack got %b want 0", ack); end
        read_byte(1'b0, d);
        tests++; if (d !== 8'h01) begin fails++; $display("FAIL read_byte1 got %h want 01", d); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'hc2) begin fails++; $display("FAIL read_byte2 got %h want c2", d); end
        bus_stop();
        quarter();
        tests++; if (reg_addr !== 8'h08) begin fails++; $display("FAIL read_end_addr got %h want 08", reg_addr); end
        tests++; if (wr_a.size() != w0) begin fails++; $display("FAIL read_no_wr got %0d want 0", wr_a.size() - w0); end
        tests++; if (rd_n - r0 != 2) begin fails++; $display("FAIL read_rd_count got %0d want 2", rd_n - r0); end
    endtask

    task automatic test_ignore();
        logic ack;
        int   w0, r0, o0, b0;
        w0 = wr_a.size(); r0 = rd_n; o0 = oe_n; b0 = busy_n;
        bus_start();
        write_byte(8'hAA, ack);
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL ignore_nack got %b want 1", ack); end
        write_byte(8'h12, ack);
        write_byte(8'h34, ack);
        bus_stop();
        quarter();
        tests++; if (oe_n != o0) begin fails++; $display("FAIL ignore_oe got %0d cycles want 0", oe_n - o0); end
        tests++; if (busy_n != b0) begin fails++; $display("FAIL ignore_busy got %0d cycles want 0", busy_n - b0); end
        tests++; if (wr_a.size() != w0 || rd_n != r0) begin fails++; $display("FAIL ignore_strobes got wr=%0d rd=%0d want 0 0", wr_a.size() - w0, rd_n - r0); end
    endtask

    task automatic test_wrap();
        logic ack;
        int   w0;
        w0 = wr_a.size();
        bus_start();
        write_byte(8'hFE, ack);
        write_byte(8'hFF, ack);
        write_byte(8'hAA, ack);
        write_byte(8'hBB, ack);
        bus_stop();
        quarter();
        tests++; if (wr_a.size() - w0 != 2) begin fails++; $display("FAIL wrap_count got %0d want 2", wr_a.size() - w0); end
        tests++; if (wr_a[w0] !== 8'hFF || wr_d[w0] !== 8'hAA) begin fails++; $display("FAIL wrap_wr0 got %h/%h want ff/aa", wr_a[w0], wr_d[w0]); end
        tests++; if (wr_a[w0+1] !== 8'h00 || wr_d[w0+1] !== 8'hBB) begin fails++; $display("FAIL wrap_wr1 got %h/%h want 00/bb", wr_a[w0+1], wr_d[w0+1]); end
        tests++; if (reg_addr !== 8'h01) begin fails++; $display("FAIL wrap_end_addr got %h want 01", reg_addr); end
    endtask

    task automatic test_reset_mid();
        logic ack, r;
        int   w0;
        w0 = wr_a.size();
        bus_start();
        write_byte(8'hFE, ack);
        write_byte(8'h10, ack);
        bus_bit(1'b0, r);
        bus_bit(1'b1, r);
        bus_bit(1'b0, r);
        sda_m = 1'b1;
        quarter();
        scl = 1'b1;
        quarter();
        reset = 1'b1;
        @(negedge clk);
        tests++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_outputs got oe=%b busy=%b want 0 0", sda_oe, busy); end
        tests++; if (reg_addr !== 8'h00) begin fails++; $display("FAIL abort_addr got %h want 00", reg_addr); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quarter();
        scl = 1'b0;
        quarter();
        tests++; if (wr_a.size() != w0) begin fails++; $display("FAIL abort_no_wr got %0d want 0", wr_a.size() - w0); end
        run_single("after_abort");
    endtask

    task automatic test_invariants();
        tests++; if (both_n != 0) begin fails++; $display("FAIL strobe_overlap got %0d want 0", both_n); end
        tests++; if (hi_chg != 0) begin fails++; $display("FAIL oe_change_scl_high got %0d want 0", hi_chg); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_read();
        test_ignore();
        test_wrap();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with a byte-wide register-access port. It decodes the initiator side of the bus, as driven by `si570_ctrl`, and turns framed transactions into register read/write strobes toward a parent-owned register file. It serves as a synthesizable Si570 stand-in for board bring-up and as the bus end of any fabric-side configuration slave. It sits between the open-drain pad logic and a register bank.

## Interface
- `I2CAddress`, default `'h7f`: 7-bit target address that is ACKed.
- `SyncStages`, default `2`: flip-flop stages on `scl`/`sda_in`. Minimum 2.
- `clk` input, 1: system clock. Must be at least 16× the SCL rate.
- `reset` input, 1: one clock; reset is asynchronous and active-high.
- `scl` input, 1: bus clock as seen at the pad. Asynchronous.
- `sda_in` input, 1: bus data as seen at the pad. Asynchronous.
- `sda_oe` output, 1: 1 = pull SDA low; 0 = release.
- `reg_addr` output, 8: register pointer.
- `reg_wr` output, 1: one-cycle write strobe.
- `reg_wdata` output, 8: write data, valid with `reg_wr`.
- `reg_rd` output, 1: one-cycle fetch strobe. The parent presents `reg_rdata` for `reg_addr` on the next cycle.
- `reg_rdata` input, 8: read data.
- `busy` output, 1: high from an addressed START until STOP.

## Operation
- Synchronize SCL/SDA through `SyncStages` flops, then detect edges on the synchronized copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. A START while not IDLE is a repeated START.
- Sample data on the rising edge of SCL. Change `sda_oe` on the falling edge of SCL only.
- FSM states:
  - IDLE → ADDR on START.
  - ADDR: shift in 8 bits. Bits [7:1] are the address and bit 0 is R/W.
    - On address match, go to ADDR_ACK.
    - On mismatch, go to IGNORE until STOP or START.
  - ADDR_ACK: drive the ACK bit.
    - W → REG.
    - R → issue `reg_rd`, go to RDATA.
  - REG: shift in 8 bits, load `reg_addr`, go to REG_ACK (ACK), then WDATA.
  - WDATA: shift in 8 bits, go to WDATA_ACK. Pulse `reg_wr` with the current `reg_addr` at the ACK-driving SCL fall, then increment `reg_addr` by 1 (wraps `'hff`→`'h00`). Go back to WDATA.
  - RDATA: shift out the latched `reg_rdata`, MSB first. `sda_oe` = ~bit.
  - RDATA_MACK: release SDA and sample the initiator's bit.
    - ACK (0): increment `reg_addr`, pulse `reg_rd`, go to RDATA.
    - NACK (1): go to IGNORE.
- STOP in any state → IDLE. START in any state → ADDR. `reg_addr` persists across transactions (current-address read).
- Bit counter is 3 bits and clears on every START or state entry.

## Timing
- Reset values: `sda_oe`=0, `reg_addr`=0, `reg_wr`=0, `reg_wdata`=0, `reg_rd`=0, `busy`=0, FSM=IDLE, counter=0.
- Input latency: `SyncStages`+1 clk from a pad edge to the internal event.
- `sda_oe` asserts or changes 1 clk after the synchronized SCL fall. It is never changed while synchronized SCL is high, so the block never emits START or STOP itself.
- ACK hold: `sda_oe` stays 1 for the full 9th SCL high and is released on the following SCL fall. In read mode, the first data bit is driven at that same fall.
- `reg_rd` → `reg_rdata` is sampled exactly 1 clk later and held in a shift register. `reg_rdata` may change afterwards.
- `reg_wr` and `reg_rd` are single-cycle pulses and never coincide.
- STOP or START mid-byte: discard the partial byte, no strobe, release `sda_oe` within 1 clk.
- Reset mid-transaction: immediate return to reset values. After release, the block waits for a START; it does not resume.

## Structure
- Package `i2c_pkg`:
  - FSM state enum: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE.
  - Constants `I2C_READ`=1 and `I2C_WRITE`=0.
  - Shared with future I2C blocks.
- Sub-module `i2c_bus_sync`: synchronizers, edge detect, and START/STOP detection. Outputs `scl_rise`, `scl_fall`, `start`, `stop`, `sda_s`. The FSM lives in the top level.

## Test plan
- Write 0x7f/W, reg 0x87, data 0x40, STOP → three ACKs. `reg_wr` pulses once with addr 0x87, data 0x40. `busy` falls after STOP.
- Write 0x7f/W, reg 0x07, data 01 c2 d1 e1 27 88 → six `reg_wr` at addresses 0x07..0x0c with those data, each byte ACKed.
- Write reg 0x07, repeated START 0x7f/R, parent model `reg_rdata`=`regs[reg_addr]` with reg7=0x01 and reg8=0xc2, initiator ACKs byte 1 and NACKs byte 2 → SDA carries 0x01 then 0xc2. `reg_addr` ends at 0x08. No `reg_wr`.
- Address 0x55/W followed by 2 bytes → `sda_oe` stays 0 throughout, no strobes, `busy` stays 0.
- Write reg 0xff, data aa bb → writes at 0xff then 0x00 (wrap-around).
- Assert `reset` during the 4th data bit, release it, then run a fresh 0x7f write → no strobe for the aborted byte, `sda_oe`=0 at once, and the new transaction behaves as in the first scenario.
